jump_config_loader: RTL and testbench
=====================================

Name: jump_config_loader

Overview:
- Upstream configuration stage for the 5-state sequencer FSM.
- Captures five 5-bit jump-select words from the shared input pins, one word per user `load` strobe, into registers that drive the FSM's `jump1`..`jump5` inputs.
- Asserts `ok` once all five words are held. This releases the FSM from its wait state.
- `load` is an asynchronous pushbutton, so it is synchronised and edge-detected here.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in the `load`/`data_in` synchronisers (min 2).
- DEBOUNCE_CYCLES, 16, cycles synchronised `load` must stay high before it counts. Used only with JUMP_LOADER_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock, all flops on rising edge
- reset  in  1  asynchronous, active-high reset; clears all state immediately
- data_in  in  5  jump word from switches; held stable by the user around each load press
- load  in  1  asynchronous strobe; each rising edge captures one word
- clear  in  1  synchronous restart of the loading sequence, active-high
- jump1..jump5  out  5 each  captured words, feed the FSM jump inputs
- ok  out  1  high when all five words are loaded (FSM start)
- word_idx  out  3  index of the next word to capture (0..4); 5 when complete
- busy  out  1  high while in FILL

Behaviour:
- Reset values (asynchronous, while reset=1):
  - jump1..jump5=0, ok=0, word_idx=0, busy=0
  - state=IDLE, synchroniser and edge flops=0
- Synchronisation:
  - `load` and `data_in` pass through SYNC_STAGES flops in parallel, so the word stays aligned with its strobe.
  - `load_pulse` = sync_load & ~sync_load_d (one extra flop).
  - With SYNC_STAGES=2, a `load` first sampled high at edge N causes the capture at edge N+2.
  - `load` held high produces exactly one pulse; it must fall and rise again for the next word.
- States:
  - IDLE: `load_pulse` captures word 0 into jump1, word_idx becomes 1, go to FILL.
  - FILL: each `load_pulse` captures into jump[word_idx+1] and increments word_idx. Capturing at word_idx=4 (into jump5) sets word_idx to 5 and goes to READY in the same edge.
  - READY: ok=1. `load_pulse` is ignored and registers hold.
- Output timing:
  - ok and busy are decoded from registered state, with no combinational path from inputs.
  - ok rises on the same edge that writes jump5.
- Clear:
  - `clear`=1 at any edge: all jump regs=0, word_idx=0, state=IDLE, ok=0.
  - Clear beats a simultaneous `load_pulse`; that word is discarded.
- Other rules:
  - No validation of word contents. Zero and multi-hot words are stored as given; the FSM resolves priority.
  - Reset asserted mid-sequence aborts immediately. The next sequence restarts at word 0.
  - word_idx never exceeds 5 and never wraps.

Optional Feature:
- Macro: JUMP_LOADER_DEBOUNCE_EN.
- Defined:
  - A counter (width clog2(DEBOUNCE_CYCLES)+1) counts consecutive cycles with sync_load=1 and resets to 0 on any low sample.
  - A debounced level goes high when the count reaches DEBOUNCE_CYCLES and low on the first low sample.
  - `load_pulse` is generated from this debounced level's rising edge, so capture latency grows by DEBOUNCE_CYCLES.
  - Glitches shorter than DEBOUNCE_CYCLES produce no capture.
- Not defined: no counter; `load_pulse` comes from the raw synchronised edge.

Decomposition:
- Shared package:
  - state encoding (IDLE=0, FILL=1, READY=2, 2 bits)
  - NUM_JUMP_WORDS=5, JUMP_W=5
  - also used by the FSM's width declarations
- Sub-module input_sync_edge:
  - synchroniser chain, optional debounce, and rising-edge pulse
  - parameterised by SYNC_STAGES and DEBOUNCE_CYCLES
  - instantiated once for `load`; `data_in` uses a plain sync chain in the top.

Test Plan:
- Reset, then load 5'h01,5'h02,5'h04,5'h08,5'h10 (load high 4 cycles, low 4) -> jump1..5 = 01,02,04,08,10; ok=1 on the edge writing jump5; word_idx=5; busy=0.
- Load 3 words, then pulse clear -> all jumps=0, word_idx=0, ok=0. Reloading 5 words of 5'h1F gives all jumps=1F, ok=1.
- In READY, load with data_in=5'h03 -> no register change, ok stays 1.
- Load held high 50 cycles with data_in=5'h04 -> only jump1=04, word_idx=1.
- Assert reset asynchronously mid-cycle at word_idx=2 -> outputs zero before the next clk edge. After release, the sequence restarts at jump1.
- With JUMP_LOADER_DEBOUNCE_EN and DEBOUNCE_CYCLES=16: a 10-cycle load glitch gives no capture; a 20-cycle press captures exactly once, 16 cycles later than without the macro.

Source files
------------

// File: rtl/jump_config_loader_pkg.sv
// Shared types and widths for the jump-config loader and the sequencer FSM it feeds.
// Optional build macro used by this slice: JUMP_LOADER_DEBOUNCE_EN.
package jump_config_loader_pkg;

    localparam int NUM_JUMP_WORDS = 5;
    localparam int JUMP_W         = 5;
    localparam int IDX_W          = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2
    } loader_state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_JUMP_WORDS - 1);

    function automatic logic is_last_word(input logic [IDX_W-1:0] idx);
        return idx == LAST_IDX;
    endfunction

endpackage

// File: rtl/jump_config_loader_input_sync_edge.sv
// Synchroniser chain plus rising-edge pulse for one asynchronous strobe.
// With JUMP_LOADER_DEBOUNCE_EN defined, the level must hold for DEBOUNCE_CYCLES before it can pulse.
module jump_config_loader_input_sync_edge #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_level;
    logic                   level;
    logic                   edge_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_level = sync_q[SYNC_STAGES-1];

`ifdef JUMP_LOADER_DEBOUNCE_EN
    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating run-length counter; any low sample restarts the qualification.
    always_comb begin
        cnt_d = cnt_q;
        if (!sync_level) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign level = (cnt_q == CNT_MAX);
`else
    assign level = sync_level;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_q <= 1'b0;
        end else begin
            edge_q <= level;
        end
    end

    assign pulse_o = level & ~edge_q;

endmodule

// File: rtl/jump_config_loader.sv
// Captures five jump-select words, one per load press, and raises ok when all are held.
// Optional build macro: JUMP_LOADER_DEBOUNCE_EN (debounces the load strobe).
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | nothing captured, waiting for the first press
//   ST_FILL  | words 1..4 captured, word_idx points at next slot
//   ST_READY | all five words held, ok=1, further presses ignored
module jump_config_loader
    import jump_config_loader_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [JUMP_W-1:0]   data_in,
    input  logic                load,
    input  logic                clear,
    output logic [JUMP_W-1:0]   jump1,
    output logic [JUMP_W-1:0]   jump2,
    output logic [JUMP_W-1:0]   jump3,
    output logic [JUMP_W-1:0]   jump4,
    output logic [JUMP_W-1:0]   jump5,
    output logic                ok,
    output logic [IDX_W-1:0]    word_idx,
    output logic                busy
);

    loader_state_e      state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [JUMP_W-1:0]  jump_q [NUM_JUMP_WORDS];
    logic [JUMP_W-1:0]  data_sync_q [SYNC_STAGES];
    logic               load_pulse;
    logic               wr_en;
    logic               clr_all;

    jump_config_loader_input_sync_edge #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_load_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (load),
        .pulse_o (load_pulse)
    );

    // Same depth as the load chain so the word arrives with its strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_sync_q[i] <= '0;
            end
        end else begin
            data_sync_q[0] <= data_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_sync_q[i] <= data_sync_q[i-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        clr_all = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            clr_all = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (load_pulse) begin
                        wr_en   = 1'b1;
                        idx_d   = IDX_W'(1);
                        state_d = ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (load_pulse) begin
                        wr_en = 1'b1;
                        idx_d = idx_q + 1'b1;
                        if (is_last_word(idx_q)) begin
                            state_d = ST_READY;
                        end
                    end
                end
                ST_READY: begin
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_JUMP_WORDS; i++) begin
                jump_q[i] <= '0;
            end
        end else if (clr_all) begin
            for (int i = 0; i < NUM_JUMP_WORDS; i++) begin
                jump_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_JUMP_WORDS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    jump_q[i] <= data_sync_q[SYNC_STAGES-1];
                end
            end
        end
    end

    assign jump1    = jump_q[0];
    assign jump2    = jump_q[1];
    assign jump3    = jump_q[2];
    assign jump4    = jump_q[3];
    assign jump5    = jump_q[4];
    assign word_idx = idx_q;
    assign ok       = (state_q == ST_READY);
    assign busy     = (state_q == ST_FILL);

endmodule

// File: tb/tb_jump_config_loader.sv
// Directed bench for jump_config_loader: vector table for the fill sequence plus hand sequences.
module tb_jump_config_loader;

`ifdef JUMP_LOADER_DEBOUNCE_EN
    localparam int LAT     = 19;
    localparam int PRESS_HI = 20;
`else
    localparam int LAT     = 3;
    localparam int PRESS_HI = 4;
`endif
    localparam int PRESS_LO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] data_in;
    logic       load;
    logic       clear;
    logic [4:0] jump1, jump2, jump3, jump4, jump5;
    logic       ok;
    logic [2:0] word_idx;
    logic       busy;

    int checks = 0;
    int errors = 0;

    jump_config_loader #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .load     (load),
        .clear    (clear),
        .jump1    (jump1),
        .jump2    (jump2),
        .jump3    (jump3),
        .jump4    (jump4),
        .jump5    (jump5),
        .ok       (ok),
        .word_idx (word_idx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  data;
        logic [2:0]  exp_idx;
        logic        exp_ok;
        logic        exp_busy;
        logic [24:0] exp_jumps;   // {jump5,jump4,jump3,jump2,jump1}
    } vec_t;

    vec_t vecs [6];

    function automatic logic [24:0] jumps();
        return {jump5, jump4, jump3, jump2, jump1};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [2:0] idx, input logic k,
                               input logic b, input logic [24:0] j);
        check({name, ".word_idx"}, 32'(word_idx), 32'(idx));
        check({name, ".ok"},       32'(ok),       32'(k));
        check({name, ".busy"},     32'(busy),     32'(b));
        check({name, ".jumps"},    32'(jumps()),  32'(j));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] d);
        data_in = d;
        load    = 1'b1;
        repeat (PRESS_HI) tick();
        load = 1'b0;
        repeat (PRESS_LO) tick();
    endtask

    initial begin
        vecs[0] = '{5'h01, 3'd1, 1'b0, 1'b1, 25'h0000001};
        vecs[1] = '{5'h02, 3'd2, 1'b0, 1'b1, 25'h0000041};
        vecs[2] = '{5'h04, 3'd3, 1'b0, 1'b1, 25'h0001041};
        vecs[3] = '{5'h08, 3'd4, 1'b0, 1'b1, 25'h0041041};
        vecs[4] = '{5'h10, 3'd5, 1'b1, 1'b0, 25'h1041041};
        vecs[5] = '{5'h03, 3'd5, 1'b1, 1'b0, 25'h1041041};   // ignored in READY

        reset   = 1'b1;
        data_in = 5'h00;
        load    = 1'b0;
        clear   = 1'b0;
        #1;
        check_state("reset", 3'd0, 1'b0, 1'b0, 25'h0);
        repeat (3) tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            data_in = vecs[i].data;
            load    = 1'b1;
            for (int t = 1; t <= PRESS_HI; t++) begin
                tick();
                if (i == 4 && t == LAT - 1) begin
                    check("ok_before_last_capture", 32'(ok), 32'd0);
                    check("jump5_before_capture", 32'(jump5), 32'h00);
                end
                if (i == 4 && t == LAT) begin
                    check("ok_with_jump5_edge", 32'(ok), 32'd1);
                    check("jump5_at_capture", 32'(jump5), 32'h10);
                end
            end
            load = 1'b0;
            repeat (PRESS_LO) tick();
            check_state($sformatf("vec%0d", i), vecs[i].exp_idx, vecs[i].exp_ok,
                        vecs[i].exp_busy, vecs[i].exp_jumps);
        end

        // Clear from READY, then partial load with a zero word, then clear mid-FILL.
        clear = 1'b1; tick(); clear = 1'b0; tick();
        check_state("clear_ready", 3'd0, 1'b0, 1'b0, 25'h0);
        press(5'h11);
        press(5'h00);
        press(5'h1E);
        check_state("three_words", 3'd3, 1'b0, 1'b1, 25'h0007811);
        clear = 1'b1; tick(); clear = 1'b0; tick();
        check_state("clear_fill", 3'd0, 1'b0, 1'b0, 25'h0);

        for (int i = 0; i < 5; i++) press(5'h1F);
        check_state("all_1f", 3'd5, 1'b1, 1'b0, 25'h1FFFFFF);

        // Clear coincident with a load pulse discards the word.
        clear = 1'b1; tick(); clear = 1'b0; tick();
        data_in = 5'h15;
        load    = 1'b1;
        repeat (LAT - 1) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_state("clear_beats_load", 3'd0, 1'b0, 1'b0, 25'h0);
        repeat (PRESS_HI) tick();
        load = 1'b0;
        repeat (PRESS_LO) tick();
        check_state("no_late_capture", 3'd0, 1'b0, 1'b0, 25'h0);

        // Held load yields exactly one capture.
        data_in = 5'h04;
        load    = 1'b1;
        repeat (50) tick();
        check_state("held_50", 3'd1, 1'b0, 1'b1, 25'h0000004);
        load = 1'b0;
        repeat (PRESS_LO) tick();

        // Asynchronous reset in mid-cycle at word_idx=2.
        press(5'h07);
        check_state("before_reset", 3'd2, 1'b0, 1'b1, 25'h00000E4);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_state("async_reset", 3'd0, 1'b0, 1'b0, 25'h0);
        #2;
        reset = 1'b0;
        tick();
        press(5'h09);
        check_state("restart_after_reset", 3'd1, 1'b0, 1'b1, 25'h0000009);

`ifdef JUMP_LOADER_DEBOUNCE_EN
        data_in = 5'h0C;
        load    = 1'b1;
        repeat (10) tick();
        load = 1'b0;
        repeat (10) tick();
        check_state("glitch_10", 3'd1, 1'b0, 1'b1, 25'h0000009);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
